// File: rtl/sci_eng_arbiter_pkg.sv
// Shared definitions for the series-expansion engine arbiter: state encodings, default widths, mode helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sci_eng_arbiter_pkg;

    // Default mode-vector and resolution widths, matching the engine build
    localparam int SCI_NUM_MODES = 3;
    localparam int SCI_RES_WIDTH = 8;

    // Widest mode vector the one-hot helper accepts
    localparam int SCI_MODE_MAX  = 16;

    // Arbiter/sequencer states, 3-bit encoding shared with the engine FSM
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // True when exactly one bit is set; narrower mode vectors are zero-extended by the caller
    function automatic logic is_onehot(input logic [SCI_MODE_MAX-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < SCI_MODE_MAX; i++) begin
            n = n + 32'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/sci_eng_arbiter_if.sv
// Requester/engine/response bundle of the engine arbiter; master = arbiter side, slave = environment side.
// Latency: n/a (wires only).
// Backpressure: request held until req_ready pulse; engine consumption signalled by eng_rd.
interface sci_eng_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_MODES  = 3,
    parameter int RES_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*NUM_MODES-1:0]  req_mode;
    logic [NUM_REQ*RES_WIDTH-1:0]  req_res;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    // Engine side
    logic                          pkt_avail;
    logic [NUM_MODES-1:0]          pkt_mode;
    logic [RES_WIDTH-1:0]          pkt_res;
    logic [DATA_WIDTH-1:0]         pkt_data;
    logic                          eng_rd;
    logic                          eng_done;
    logic [DATA_WIDTH-1:0]         eng_result;

    // Response side
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_err;
    logic                          busy;

    modport master (
        input  req_valid, req_mode, req_res, req_data,
        input  eng_rd, eng_done, eng_result,
        output req_ready,
        output pkt_avail, pkt_mode, pkt_res, pkt_data,
        output resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        output req_valid, req_mode, req_res, req_data,
        output eng_rd, eng_done, eng_result,
        input  req_ready,
        input  pkt_avail, pkt_mode, pkt_res, pkt_data,
        input  resp_valid, resp_data, resp_err, busy
    );

endinterface

// File: rtl/sci_eng_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is taken.
module sci_eng_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_o
);

    // Walk the requests starting at the pointer; the first hit wins
    always_comb begin
        int idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sci_eng_arbiter.sv
// Round-robin arbiter/sequencer sharing one series-expansion engine; screens illegal jobs. Optional watchdog: SCI_ARB_WDOG_EN.
// Latency: request -> pkt_avail 2 cycles; eng_done -> resp_valid 1 cycle; rejects answer 2 cycles after the request.
// Backpressure: one job in flight; requesters hold req_valid until their req_ready pulse; pkt_avail held until eng_rd.
module sci_eng_arbiter
    import sci_eng_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_MODES   = SCI_NUM_MODES,
    parameter int RES_WIDTH   = SCI_RES_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,   // synchronous, active-high
    sci_eng_arbiter_if.master bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_MODES > SCI_MODE_MAX || WDOG_CYCLES < 2) begin : g_bad_params
        $error("sci_eng_arbiter: need NUM_REQ >= 2, NUM_MODES <= 16, WDOG_CYCLES >= 2");
    end

    // FSM state and job registers
    state_e                state_q,  state_d;
    logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MODES-1:0]  mode_q,   mode_d;
    logic [RES_WIDTH-1:0]  res_q,    res_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  err_q,    err_d;

    // Round-robin pick and the winner's payload
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;
    logic [NUM_MODES-1:0]  win_mode;
    logic [RES_WIDTH-1:0]  win_res;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  job_ok;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic                  pkt_on;
    logic                  wdog_hit;

    sci_eng_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i    (bus.req_valid),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .gnt_id_o (pick_id),
        .any_o    (pick_any)
    );

    // AND-OR select of the winning requester's packed payload using the one-hot grant
    always_comb begin
        win_mode = '0;
        win_res  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_mode = win_mode | bus.req_mode[i*NUM_MODES +: NUM_MODES];
                win_res  = win_res  | bus.req_res[i*RES_WIDTH +: RES_WIDTH];
                win_data = win_data | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Illegal jobs (mode not one-hot, fewer than 2 terms) would hang or underflow the engine
    assign job_ok = is_onehot(SCI_MODE_MAX'(mode_q)) && (res_q >= RES_WIDTH'(2));
    assign gnt_oh = NUM_REQ'(1) << gnt_id_q;

`ifdef SCI_ARB_WDOG_EN
    logic [15:0] wdog_q, wdog_d;

    assign wdog_hit = (wdog_q == 16'(WDOG_CYCLES - 1));

    // Watchdog counter: zeroed when the job enters ISSUE, advances through ISSUE and RUN
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_LATCH) begin
            wdog_d = '0;
        end else if (state_q == ST_ISSUE || state_q == ST_RUN) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // Watchdog register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Next-state and job-register update; a completed engine result beats a coincident timeout
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        rr_ptr_d = rr_ptr_q;
        mode_d   = mode_q;
        res_d    = res_q;
        data_d   = data_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_LATCH;
                    gnt_id_d = pick_id;
                    mode_d   = win_mode;
                    res_d    = win_res;
                    data_d   = win_data;
                    result_d = '0;
                    err_d    = 1'b0;
                    rr_ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                end
            end
            ST_LATCH: begin
                if (!job_ok) begin
                    state_d  = ST_RESP;
                    err_d    = 1'b1;
                    result_d = '0;
                end else begin
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.eng_rd && bus.eng_done) begin
                    state_d  = ST_RESP;
                    result_d = bus.eng_result;
                    err_d    = 1'b0;
                end else if (wdog_hit) begin
                    state_d  = ST_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                end else if (bus.eng_rd) begin
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.eng_done) begin
                    state_d  = ST_RESP;
                    result_d = bus.eng_result;
                    err_d    = 1'b0;
                end else if (wdog_hit) begin
                    state_d  = ST_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and job registers; reset abandons any job in flight without a response
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= '0;
            rr_ptr_q <= '0;
            mode_q   <= '0;
            res_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            rr_ptr_q <= rr_ptr_d;
            mode_q   <= mode_d;
            res_q    <= res_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode straight from registered state, so every output is 0 in IDLE
    assign pkt_on         = (state_q == ST_ISSUE) || (state_q == ST_RUN);
    assign bus.req_ready  = (state_q == ST_LATCH) ? gnt_oh : '0;
    assign bus.pkt_avail  = (state_q == ST_ISSUE);
    assign bus.pkt_mode   = pkt_on ? mode_q : '0;
    assign bus.pkt_res    = pkt_on ? res_q  : '0;
    assign bus.pkt_data   = pkt_on ? data_q : '0;
    assign bus.resp_valid = (state_q == ST_RESP) ? gnt_oh : '0;
    assign bus.resp_data  = (state_q == ST_RESP) ? result_q : '0;
    assign bus.resp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sci_eng_arbiter.sv
// Directed bench for the engine arbiter: reset, normal job, rr wrap, rejects, rd/done overlap, mid-job reset, watchdog.
// Latency: checks request->pkt_avail and done->resp timing cycle by cycle.
// Backpressure: requesters drop req_valid on their req_ready pulse unless a test holds it.
module tb_sci_eng_arbiter;

    localparam int NR = 4;
    localparam int NM = 3;
    localparam int RW = 8;
    localparam int DW = 32;
    localparam int WD = 16;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    sci_eng_arbiter_if #(
        .NUM_REQ    (NR),
        .NUM_MODES  (NM),
        .RES_WIDTH  (RW),
        .DATA_WIDTH (DW)
    ) bus ();

    sci_eng_arbiter #(
        .NUM_REQ     (NR),
        .NUM_MODES   (NM),
        .RES_WIDTH   (RW),
        .DATA_WIDTH  (DW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [NM-1:0] m, input logic [RW-1:0] r,
                           input logic [DW-1:0] d);
        bus.req_mode[i*NM +: NM] = m;
        bus.req_res[i*RW +: RW]  = r;
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Legal job from grant to response; the request must already be presented
    task automatic job(input int id, input logic [DW-1:0] exp_data, input logic [DW-1:0] result,
                       input bit hold);
        logic [NR-1:0] oh;
        oh = NR'(1) << id;
        tick();
        chk("job_ready", 64'(bus.req_ready), 64'(oh));
        if (!hold) bus.req_valid[id] = 1'b0;
        tick();
        chk("job_pkt_avail", 64'(bus.pkt_avail), 64'd1);
        chk("job_pkt_data", 64'(bus.pkt_data), 64'(exp_data));
        bus.eng_rd = 1'b1;
        tick();
        bus.eng_rd = 1'b0;
        chk("job_pkt_drop", 64'(bus.pkt_avail), 64'd0);
        bus.eng_done   = 1'b1;
        bus.eng_result = result;
        tick();
        bus.eng_done = 1'b0;
        chk("job_resp_valid", 64'(bus.resp_valid), 64'(oh));
        chk("job_resp_data", 64'(bus.resp_data), 64'(result));
        chk("job_resp_err", 64'(bus.resp_err), 64'd0);
        tick();
        chk("job_resp_pulse", 64'(bus.resp_valid), 64'd0);
    endtask

    // Illegal job: ready pulse, engine untouched, error response next cycle
    task automatic reject(input int id);
        logic [NR-1:0] oh;
        oh = NR'(1) << id;
        tick();
        chk("rej_ready", 64'(bus.req_ready), 64'(oh));
        chk("rej_pkt_latch", 64'(bus.pkt_avail), 64'd0);
        bus.req_valid[id] = 1'b0;
        tick();
        chk("rej_pkt_resp", 64'(bus.pkt_avail), 64'd0);
        chk("rej_resp_valid", 64'(bus.resp_valid), 64'(oh));
        chk("rej_resp_err", 64'(bus.resp_err), 64'd1);
        chk("rej_resp_data", 64'(bus.resp_data), 64'd0);
        tick();
        chk("rej_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b1;
        bus.req_valid  = '0;
        bus.req_mode   = '0;
        bus.req_res    = '0;
        bus.req_data   = '0;
        bus.eng_rd     = 1'b0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_pkt_avail", 64'(bus.pkt_avail), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        rst_n = 1'b0;

        // T1: single legal job, result 0xCAFE
        set_req(0, 3'b010, 8'd8, 32'h0000_1234);
        bus.req_valid = 4'b0001;
        tick();
        chk("t1_ready", 64'(bus.req_ready), 64'h1);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_no_pkt_yet", 64'(bus.pkt_avail), 64'd0);
        bus.req_valid = 4'b0000;
        tick();
        chk("t1_pkt_avail", 64'(bus.pkt_avail), 64'd1);
        chk("t1_pkt_mode", 64'(bus.pkt_mode), 64'h2);
        chk("t1_pkt_res", 64'(bus.pkt_res), 64'd8);
        chk("t1_pkt_data", 64'(bus.pkt_data), 64'h1234);
        bus.eng_rd = 1'b1;
        tick();
        bus.eng_rd = 1'b0;
        chk("t1_pkt_drop", 64'(bus.pkt_avail), 64'd0);
        chk("t1_mode_held", 64'(bus.pkt_mode), 64'h2);
        bus.eng_done   = 1'b1;
        bus.eng_result = 32'h0000_CAFE;
        tick();
        bus.eng_done = 1'b0;
        chk("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
        chk("t1_resp_data", 64'(bus.resp_data), 64'hCAFE);
        chk("t1_resp_err", 64'(bus.resp_err), 64'd0);
        chk("t1_pkt_mode_clr", 64'(bus.pkt_mode), 64'd0);
        tick();
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);
        chk("t1_resp_pulse", 64'(bus.resp_valid), 64'd0);

        // T2: all four held after a reset (pointer 0) -> grants 0,1,2,3,0
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 3'b001, 8'd4, 32'h100 + 32'(i));
        end
        bus.req_valid = 4'b1111;
        job(0, 32'h100, 32'hA0, 1'b1);
        job(1, 32'h101, 32'hA1, 1'b1);
        job(2, 32'h102, 32'hA2, 1'b1);
        job(3, 32'h103, 32'hA3, 1'b1);
        job(0, 32'h100, 32'hA4, 1'b1);
        bus.req_valid = 4'b0000;

        // T3: requester 2 with non-one-hot mode
        set_req(2, 3'b011, 8'd8, 32'h0000_0222);
        bus.req_valid = 4'b0100;
        reject(2);

        // T4: requester 1 with res=1 rejected, then res=2 accepted
        set_req(1, 3'b001, 8'd1, 32'h0000_0055);
        bus.req_valid = 4'b0010;
        reject(1);
        set_req(1, 3'b001, 8'd2, 32'h0000_0066);
        bus.req_valid = 4'b0010;
        job(1, 32'h66, 32'h77, 1'b0);

        // T7: lone eng_done in ISSUE ignored; eng_rd with eng_done together completes the job
        set_req(0, 3'b100, 8'd3, 32'h0000_00AA);
        bus.req_valid = 4'b0001;
        tick();
        chk("t7_ready", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 4'b0000;
        tick();
        bus.eng_done   = 1'b1;
        bus.eng_result = 32'h0000_DEAD;
        tick();
        bus.eng_done = 1'b0;
        chk("t7_still_issue", 64'(bus.pkt_avail), 64'd1);
        chk("t7_no_resp", 64'(bus.resp_valid), 64'd0);
        bus.eng_rd     = 1'b1;
        bus.eng_done   = 1'b1;
        bus.eng_result = 32'h0000_BEEF;
        tick();
        bus.eng_rd   = 1'b0;
        bus.eng_done = 1'b0;
        chk("t7_resp_valid", 64'(bus.resp_valid), 64'h1);
        chk("t7_resp_data", 64'(bus.resp_data), 64'hBEEF);
        chk("t7_pkt_off", 64'(bus.pkt_avail), 64'd0);
        tick();

        // T5: reset while the engine is running
        set_req(3, 3'b001, 8'd5, 32'h0000_0033);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bus.eng_rd = 1'b1;
        tick();
        bus.eng_rd = 1'b0;
        chk("t5_run_busy", 64'(bus.busy), 64'd1);
        chk("t5_run_pkt_data", 64'(bus.pkt_data), 64'h33);
        rst_n = 1'b1;
        tick();
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_pkt_data", 64'(bus.pkt_data), 64'd0);
        chk("t5_pkt_mode", 64'(bus.pkt_mode), 64'd0);
        chk("t5_ready", 64'(bus.req_ready), 64'd0);
        chk("t5_resp_valid", 64'(bus.resp_valid), 64'd0);
        rst_n          = 1'b0;
        bus.eng_done   = 1'b1;
        bus.eng_result = 32'h0000_0001;
        tick();
        bus.eng_done = 1'b0;
        chk("t5_late_done", 64'(bus.resp_valid), 64'd0);
        chk("t5_late_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("t5_late_done2", 64'(bus.resp_valid), 64'd0);

`ifdef SCI_ARB_WDOG_EN
        // T6: engine never finishes -> timeout 16 cycles after ISSUE entry
        begin
            int n;
            set_req(0, 3'b001, 8'd4, 32'h0000_0011);
            bus.req_valid = 4'b0001;
            tick();
            bus.req_valid = 4'b0000;
            tick();
            chk("t6_issue", 64'(bus.pkt_avail), 64'd1);
            n = 0;
            bus.eng_rd = 1'b1;
            do begin
                tick();
                bus.eng_rd = 1'b0;
                n++;
            end while (bus.resp_valid == '0 && n < 40);
            chk("t6_timeout_cycles", 64'(n), 64'd16);
            chk("t6_resp_valid", 64'(bus.resp_valid), 64'h1);
            chk("t6_resp_err", 64'(bus.resp_err), 64'd1);
            chk("t6_resp_data", 64'(bus.resp_data), 64'd0);
            tick();
            chk("t6_idle", 64'(bus.busy), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
